// File: rtl/bridge_pkg.sv
// Shared types for the SRAM-like to AXI bridge: write FSM states and AXI size codes.
package bridge_pkg;

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_SEND   = 2'd1,
        W_WAIT_B = 2'd2
    } wstate_t;

    typedef enum logic [2:0] {
        AXI_SIZE_1B = 3'd0,
        AXI_SIZE_2B = 3'd1,
        AXI_SIZE_4B = 3'd2,
        AXI_SIZE_8B = 3'd3
    } axi_size_e;

    // SRAM size is already log2(bytes), so the AXI code is a zero-extension.
    function automatic axi_size_e axi_size(input logic [1:0] s);
        return axi_size_e'({1'b0, s});
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant; the pointer moves past the winner only when a grant is issued.
module rr_arbiter #(
    parameter int NUM_CH = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [NUM_CH-1:0] req,
    output logic [NUM_CH-1:0] grant
);
    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] win;
    logic             found;
    int               idx;

    always_comb begin
        grant = '0;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                win        = PTR_W'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (win == PTR_W'(NUM_CH - 1)) ? '0 : win + 1'b1;
        end
    end

endmodule

// File: rtl/sram_axi_bridge.sv
// Multi-channel SRAM-like to AXI bridge: one AR slot, one write FSM, one outstanding op per channel.
module sram_axi_bridge
    import bridge_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [NUM_CH-1:0]          req,
    input  logic [NUM_CH-1:0]          wr,
    input  logic [2*NUM_CH-1:0]        size,
    input  logic [NUM_CH*ADDR_W-1:0]   addr,
    input  logic [NUM_CH*DATA_W/8-1:0] wstrb,
    input  logic [NUM_CH*DATA_W-1:0]   wdata,
    output logic [NUM_CH-1:0]          addr_ok,
    output logic [NUM_CH-1:0]          data_ok,
    output logic [NUM_CH*DATA_W-1:0]   rdata,
    output logic [ID_W-1:0]            arid,
    output logic [ADDR_W-1:0]          araddr,
    output logic [2:0]                 arsize,
    output logic                       arvalid,
    input  logic                       arready,
    input  logic [ID_W-1:0]            rid,
    input  logic [DATA_W-1:0]          rdata_axi,
    input  logic                       rvalid,
    output logic                       rready,
    output logic [ID_W-1:0]            awid,
    output logic [ADDR_W-1:0]          awaddr,
    output logic [2:0]                 awsize,
    output logic                       awvalid,
    input  logic                       awready,
    output logic [DATA_W-1:0]          wdata_axi,
    output logic [DATA_W/8-1:0]        wstrb_axi,
    output logic                       wvalid,
    input  logic                       wready,
    input  logic [ID_W-1:0]            bid,
    input  logic                       bvalid,
    output logic                       bready
);
    localparam int STRB_W = DATA_W / 8;

    wstate_t             wstate, wstate_nx;
    logic [NUM_CH-1:0]   busy, eligible, grant, r_hit, b_hit;
    logic                accept;
    logic                ar_valid_q;
    logic [ADDR_W-1:0]   ar_addr_q, w_addr_q, sel_addr;
    logic [2:0]          ar_size_q;
    logic [ID_W-1:0]     ar_id_q, w_owner_q, sel_id;
    logic [1:0]          w_size_q, sel_size;
    logic [STRB_W-1:0]   w_strb_q, sel_strb;
    logic [DATA_W-1:0]   w_data_q, sel_data;
    logic                sel_wr, aw_done, w_done;
    logic                unused_bid;

    assign unused_bid = ^bid;

    // A read must not overtake a pending write to the same word.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (req[i] && !busy[i]) begin
                if (wr[i])
                    eligible[i] = (wstate == W_IDLE);
                else
                    eligible[i] = !ar_valid_q &&
                        !((wstate != W_IDLE) &&
                          (w_addr_q[ADDR_W-1:2] == addr[i*ADDR_W+2 +: ADDR_W-2]));
            end
        end
    end

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .clk    (clk),
        .resetn (resetn),
        .req    (eligible & {NUM_CH{resetn}}),
        .grant  (grant)
    );

    assign addr_ok = grant;
    assign accept  = |grant;

    always_comb begin
        sel_addr = '0;
        sel_size = '0;
        sel_strb = '0;
        sel_data = '0;
        sel_wr   = 1'b0;
        sel_id   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                sel_addr = addr[i*ADDR_W +: ADDR_W];
                sel_size = size[i*2 +: 2];
                sel_strb = wstrb[i*STRB_W +: STRB_W];
                sel_data = wdata[i*DATA_W +: DATA_W];
                sel_wr   = wr[i];
                sel_id   = ID_W'(i);
            end
        end
    end

    // Out-of-range or unexpected R beats match no channel and fall through.
    always_comb begin
        r_hit = '0;
        b_hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            r_hit[i] = rvalid && (rid == ID_W'(i)) && busy[i];
            b_hit[i] = (wstate == W_WAIT_B) && bvalid && (w_owner_q == ID_W'(i));
        end
    end

    always_comb begin
        wstate_nx = wstate;
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        bready    = 1'b0;
        case (wstate)
            W_IDLE: if (accept && sel_wr) wstate_nx = W_SEND;
            W_SEND: begin
                awvalid = !aw_done;
                wvalid  = !w_done;
                if ((aw_done || awready) && (w_done || wready)) wstate_nx = W_WAIT_B;
            end
            W_WAIT_B: begin
                bready = 1'b1;
                if (bvalid) wstate_nx = W_IDLE;
            end
            default: wstate_nx = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wstate  <= W_IDLE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            wstate <= wstate_nx;
            if (wstate_nx != W_SEND) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else begin
                if (awvalid && awready) aw_done <= 1'b1;
                if (wvalid && wready) w_done <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy       <= '0;
            data_ok    <= '0;
            rdata      <= '0;
            ar_valid_q <= 1'b0;
            ar_addr_q  <= '0;
            ar_size_q  <= '0;
            ar_id_q    <= '0;
            w_addr_q   <= '0;
            w_size_q   <= '0;
            w_strb_q   <= '0;
            w_data_q   <= '0;
            w_owner_q  <= '0;
        end else begin
            busy    <= (busy & ~(r_hit | b_hit)) | grant;
            data_ok <= r_hit | b_hit;
            for (int i = 0; i < NUM_CH; i++)
                if (r_hit[i]) rdata[i*DATA_W +: DATA_W] <= rdata_axi;
            if (accept && !sel_wr) begin
                ar_valid_q <= 1'b1;
                ar_addr_q  <= sel_addr;
                ar_size_q  <= axi_size(sel_size);
                ar_id_q    <= sel_id;
            end else if (arready) begin
                ar_valid_q <= 1'b0;
            end
            if (accept && sel_wr) begin
                w_addr_q  <= sel_addr;
                w_size_q  <= sel_size;
                w_strb_q  <= sel_strb;
                w_data_q  <= sel_data;
                w_owner_q <= sel_id;
            end
        end
    end

    assign arvalid   = ar_valid_q;
    assign araddr    = ar_addr_q;
    assign arsize    = ar_size_q;
    assign arid      = ar_id_q;
    assign rready    = 1'b1;
    assign awid      = w_owner_q;
    assign awaddr    = w_addr_q;
    assign awsize    = axi_size(w_size_q);
    assign wdata_axi = w_data_q;
    assign wstrb_axi = w_strb_q;

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge with two channels and a hand-driven AXI slave.
module tb_sram_axi_bridge;
    logic        clk = 1'b0;
    logic        resetn;
    logic [1:0]  req, wr, addr_ok, data_ok;
    logic [3:0]  size;
    logic [63:0] addr, wdata, rdata;
    logic [7:0]  wstrb;
    logic [3:0]  arid, rid, awid, bid;
    logic [31:0] araddr, awaddr, rdata_axi, wdata_axi;
    logic [2:0]  arsize, awsize;
    logic        arvalid, arready, rvalid, rready, awvalid, awready;
    logic [3:0]  wstrb_axi;
    logic        wvalid, wready, bvalid, bready;

    int checks = 0;
    int failures = 0;

    sram_axi_bridge dut (
        .clk(clk), .resetn(resetn), .req(req), .wr(wr), .size(size), .addr(addr),
        .wstrb(wstrb), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
        .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata_axi(rdata_axi), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata_axi(wdata_axi), .wstrb_axi(wstrb_axi), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req = '0; wr = '0; size = 4'b1010; addr = '0; wstrb = '0; wdata = '0;
        arready = 0; rvalid = 0; rid = '0; rdata_axi = '0;
        awready = 0; wready = 0; bvalid = 0; bid = '0;
    endtask

    task automatic reset_dut();
        idle_inputs();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
    endtask

    int         n_acc, viol, aw_cnt, w_cnt, doks;
    logic [1:0] outst;
    logic       order [4];
    logic       pend_v;
    logic [3:0] pend_id;

    initial begin
        idle_inputs();
        resetn = 1'b0;
        req = 2'b11;
        #2;
        chk("rst_addr_ok", addr_ok, 0);
        chk("rst_data_ok", data_ok, 0);
        chk("rst_valids", {arvalid, awvalid, wvalid, bready}, 0);
        chk("rst_rready", rready, 1);
        chk("rst_rdata", rdata, 0);
        tick();
        tick();

        // ch0 read, first acceptance right after reset release
        idle_inputs();
        resetn = 1'b1;
        req = 2'b01; addr[31:0] = 32'h1C00_0000;
        #1;
        chk("rd_addr_ok", addr_ok, 2'b01);
        tick();
        req = 2'b00;
        chk("rd_arvalid", arvalid, 1);
        chk("rd_ar_fields", {araddr, arsize, arid}, {32'h1C00_0000, 3'd2, 4'd0});
        tick();
        chk("rd_ar_hold", {arvalid, araddr}, {1'b1, 32'h1C00_0000});
        arready = 1;
        tick();
        arready = 0;
        chk("rd_ar_done", arvalid, 0);
        rvalid = 1; rid = 4'd2; rdata_axi = 32'hDEAD_0000;
        tick();
        chk("rd_bad_rid", data_ok, 0);
        rid = 4'd0; rdata_axi = 32'h0240_0000;
        #1;
        chk("rd_no_early_ok", data_ok, 0);
        tick();
        rvalid = 0;
        chk("rd_data_ok", data_ok, 2'b01);
        chk("rd_rdata0", rdata[31:0], 32'h0240_0000);
        tick();
        chk("rd_ok_pulse", data_ok, 0);

        // round-robin with both channels requesting every cycle
        reset_dut();
        req = 2'b11; addr = {32'h0000_2000, 32'h0000_1000}; arready = 1;
        n_acc = 0; viol = 0; pend_v = 0; pend_id = '0; outst = '0;
        for (int k = 0; k < 40 && n_acc < 4; k++) begin
            rvalid = pend_v; rid = pend_id; rdata_axi = 32'h100 + k;
            #1;
            for (int i = 0; i < 2; i++) if (data_ok[i]) outst[i] = 1'b0;
            if (addr_ok == 2'b01 || addr_ok == 2'b10) begin
                if (outst[addr_ok[1]]) viol++;
                outst[addr_ok[1]] = 1'b1;
                order[n_acc] = addr_ok[1];
                n_acc++;
            end else if (addr_ok != 2'b00) begin
                viol++;
            end
            pend_v = arvalid; pend_id = arid;
            tick();
        end
        chk("rr_count", n_acc, 4);
        chk("rr_order", {order[0], order[1], order[2], order[3]}, 4'b0101);
        chk("rr_one_outstanding", viol, 0);

        // read-after-write hold
        reset_dut();
        req = 2'b10; wr = 2'b10; addr[63:32] = 32'h100; wstrb[7:4] = 4'hF; wdata[63:32] = 32'hDEAD_BEEF;
        #1;
        chk("raw_wr_ok", addr_ok, 2'b10);
        tick();
        req = 2'b01; wr = 2'b00; addr[31:0] = 32'h100;
        #1;
        chk("raw_aw", {awvalid, wvalid, awaddr, awid, awsize}, {2'b11, 32'h100, 4'd1, 3'd2});
        chk("raw_w", {wdata_axi, wstrb_axi}, {32'hDEAD_BEEF, 4'hF});
        chk("raw_hold_send", addr_ok, 0);
        awready = 1; wready = 1;
        tick();
        awready = 0; wready = 0;
        chk("raw_wait_b", {bready, awvalid, wvalid, arvalid, addr_ok}, {4'b1000, 2'b00});
        tick();
        chk("raw_hold_b", addr_ok, 0);
        bvalid = 1; bid = 4'd1;
        #1;
        chk("raw_hold_bvalid", addr_ok, 0);
        tick();
        bvalid = 0;
        chk("raw_data_ok", {data_ok, addr_ok, arvalid}, {2'b10, 2'b01, 1'b0});
        tick();
        req = 2'b00;
        chk("raw_ar", {arvalid, araddr, arid}, {1'b1, 32'h100, 4'd0});

        // W handshake three cycles ahead of AW
        reset_dut();
        req = 2'b10; wr = 2'b10; addr[63:32] = 32'h200; wstrb[7:4] = 4'h3; wdata[63:32] = 32'h1234;
        tick();
        req = 2'b00;
        aw_cnt = 0; w_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            wready = (k == 0); awready = (k == 3);
            #1;
            if (awvalid && awready) aw_cnt++;
            if (wvalid && wready) w_cnt++;
            tick();
        end
        wready = 0; awready = 0;
        chk("split_aw_beats", aw_cnt, 1);
        chk("split_w_beats", w_cnt, 1);
        chk("split_bready", bready, 1);
        bvalid = 1; bid = 4'd1;
        tick();
        bvalid = 0;
        doks = 0;
        for (int k = 0; k < 4; k++) begin
            if (data_ok[1]) doks++;
            tick();
        end
        chk("split_data_ok_once", doks, 1);

        // simultaneous R and B completions
        reset_dut();
        req = 2'b10; wr = 2'b10; addr[63:32] = 32'h300;
        #1;
        chk("rb_wr_ok", addr_ok, 2'b10);
        tick();
        req = 2'b01; wr = 2'b00; addr[31:0] = 32'h400; awready = 1; wready = 1;
        #1;
        chk("rb_rd_ok", addr_ok, 2'b01);
        tick();
        req = 2'b00; awready = 0; wready = 0; arready = 1;
        chk("rb_state", {bready, arvalid}, 2'b11);
        tick();
        arready = 0;
        bvalid = 1; bid = 4'd1; rvalid = 1; rid = 4'd0; rdata_axi = 32'hA5A5_A5A5;
        #1;
        chk("rb_no_early_ok", data_ok, 0);
        tick();
        bvalid = 0; rvalid = 0;
        chk("rb_data_ok", data_ok, 2'b11);
        chk("rb_rdata0", rdata[31:0], 32'hA5A5_A5A5);

        // reset while waiting for B, then a stale B and R
        reset_dut();
        req = 2'b10; wr = 2'b10; addr[63:32] = 32'h500;
        tick();
        req = 2'b00; awready = 1; wready = 1;
        tick();
        awready = 0; wready = 0;
        chk("stale_in_wait_b", bready, 1);
        resetn = 1'b0;
        #1;
        chk("stale_rst_valids", {arvalid, awvalid, wvalid, bready, data_ok}, 0);
        tick();
        resetn = 1'b1;
        bvalid = 1; bid = 4'd1; rvalid = 1; rid = 4'd1;
        tick();
        bvalid = 0; rvalid = 0;
        chk("stale_no_ok", {data_ok, bready}, 0);
        tick();
        chk("stale_no_ok_late", data_ok, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sram_axi_bridge.md
SRAM_AXI_BRIDGE -- requirements
Module: sram_axi_bridge

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of SRAM-like request channels (ch0 inst, ch1 data).
REQ-002 SHALL have parameter ADDR_W, default 32, address width.
REQ-003 SHALL have parameter DATA_W, default 32, data width; the byte-strobe width is DATA_W/8.
REQ-004 SHALL have parameter ID_W, default 4, AXI ID width; ID_W SHALL be at least clog2(NUM_CH).
REQ-005 SHALL use one clock and an asynchronous, active-low reset:
  clk  in  1  sole clock, rising edge.
  resetn  in  1  asynchronous, active-low reset.
REQ-006 SHALL provide these SRAM-like ports; all are flattened, channel i occupies slice i:
  req  in  NUM_CH  request.
  wr  in  NUM_CH  1=write.
  size  in  2*NUM_CH  log2 bytes.
  addr  in  NUM_CH*ADDR_W  byte address.
  wstrb  in  NUM_CH*DATA_W/8  byte enables.
  wdata  in  NUM_CH*DATA_W  write data.
  addr_ok  out  NUM_CH  request accepted.
  data_ok  out  NUM_CH  read data or write completion.
  rdata  out  NUM_CH*DATA_W  read data.
REQ-007 SHALL provide these AXI ports; all transfers are single-beat:
  arid  out  ID_W;  araddr  out  ADDR_W;  arsize  out  3;  arvalid  out  1;  arready  in  1.
  rid  in  ID_W;  rdata_axi  in  DATA_W;  rvalid  in  1;  rready  out  1.
  awid  out  ID_W;  awaddr  out  ADDR_W;  awsize  out  3;  awvalid  out  1;  awready  in  1.
  wdata_axi  out  DATA_W;  wstrb_axi  out  DATA_W/8;  wvalid  out  1;  wready  in  1.
  bid  in  ID_W;  bvalid  in  1;  bready  out  1.

Function
REQ-008 SHALL accept a request on channel i only in a cycle where req[i] and addr_ok[i] are both 1.
REQ-009 SHALL drive addr_ok combinationally and SHALL assert it for at most one channel per cycle.
REQ-010 SHALL treat channel i as eligible only when it has no outstanding operation (busy[i]=0).
REQ-011 SHALL make an eligible read wait additionally until the AR slot is empty and no pending write matches addr[ADDR_W-1:2] (read-after-write hold).
REQ-012 SHALL make an eligible write wait additionally until the write FSM is IDLE.
REQ-013 SHALL select among eligible requesting channels by round-robin from pointer ptr; after an acceptance, ptr SHALL become winner+1 mod NUM_CH, otherwise it holds.
REQ-014 On accepting a read, SHALL in the next cycle drive arvalid=1 with araddr=addr, arsize={0,size}, arid=i, and hold these stable until arready.
REQ-015 On accepting a write, SHALL register addr, size, wstrb, wdata and owner, and SHALL move the write FSM IDLE->SEND.
REQ-016 In SEND, SHALL assert awvalid until aw_done and wvalid until w_done; the two handshakes may complete in either order or in the same cycle.
REQ-017 When both aw_done and w_done are set, SHALL move SEND->WAIT_B.
REQ-018 In WAIT_B, SHALL assert bready; on bvalid, SHALL move to IDLE, pulse data_ok[owner] for one cycle in the next cycle, and clear busy[owner].
REQ-019 SHALL hold rready at 1 permanently.
REQ-020 On rvalid, SHALL register rdata_axi into rdata slice rid, pulse data_ok[rid] the next cycle, and clear busy[rid].
REQ-021 SHALL silently drop an R beat with rid >= NUM_CH or with busy[rid]=0.
REQ-022 SHALL honour R and B completions for different channels arriving in the same cycle; both data_ok pulses SHALL occur in the same cycle.
REQ-023 SHALL allow a new request to be accepted on channel i in the same cycle that data_ok[i] is pulsed.
REQ-024 SHALL apply pointer wrap for NUM_CH not a power of two.

Reset
REQ-025 While resetn=0, SHALL force arvalid, awvalid, wvalid, bready, data_ok, addr_ok, busy and ptr to 0, rdata to 0, and the write FSM to IDLE; rready stays 1.
REQ-026 SHALL abandon in-flight transactions on reset and SHALL NOT issue data_ok for them afterwards.
REQ-027 SHALL allow the first acceptance in the first cycle after resetn rises.

Structure
REQ-028 SHALL place the write-FSM state enum (IDLE, SEND, WAIT_B) and the AXI size encodings in shared package bridge_pkg.
REQ-029 SHALL implement round-robin selection in one sub-module rr_arbiter, parametrised by NUM_CH.

Verification
REQ-030 Bench SHALL cover: ch0 read at 0x1C000000, arready after 2 cycles, R with rid=0 and data 0x02400000 -> data_ok[0] one cycle later, rdata slice0=0x02400000.
REQ-031 Bench SHALL cover: ch0 and ch1 both requesting every cycle with ptr=0 -> acceptance order 0,1,0,1, each channel held to one outstanding.
REQ-032 Bench SHALL cover: ch1 write to 0x100 with wstrb=0xF, then ch0 read of 0x100 -> ch0 read held until bvalid, arvalid the cycle after data_ok[1].
REQ-033 Bench SHALL cover: wready 3 cycles before awready -> single AW and single W beat, B -> data_ok[1] pulse exactly once.
REQ-034 Bench SHALL cover: R(rid=0) and B(bid=1) in the same cycle -> data_ok=2'b11 the next cycle.
REQ-035 Bench SHALL cover: resetn low while in WAIT_B -> FSM IDLE, all valids 0, and no data_ok when a stale B arrives.
